muldiv_sequencer: RTL and testbench

Iterative multiply/divide unit that sits beside the EX-stage ALU and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-step shift-add or restoring-divide sequence. While busy, it raises a stall to the hazard logic. It also serves MFHI/MFLO reads, stalling them until any in-flight result has landed.

---
 rtl/muldiv_sequencer_if.sv | 34 +++
 rtl/muldiv_sequencer.sv | 179 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_if
// Description : EX-stage <-> multiply/divide unit bundle.
//               master : pipeline side (drives start/funct/a/b/flush).
//               slave  : muldiv_sequencer (drives stall/done/div_zero/hi/lo/rd_data).
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output start, funct, a, b, flush,
        input  stall, done, div_zero, hi, lo, rd_data
    );

    modport slave (
        input  start, funct, a, b, flush,
        output stall, done, div_zero, hi, lo, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair.
//               One shift-add (multiply) or restoring-divide step per cycle,
//               WIDTH steps per op, then a sign fix-up cycle writes HI/LO.
//               Serves MFHI/MFLO combinationally and stalls the pipeline
//               while a result is still in flight.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               bus (slave)   - start/funct/a/b/flush in;
//                               stall/done/div_zero/hi/lo/rd_data out
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    muldiv_sequencer_if.slave  bus
);

    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;
    localparam int         c_CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [c_CW-1:0]  r_cnt;
    logic             r_is_div;
    logic             r_neg_q;     // negate product / quotient at fix-up
    logic             r_neg_r;     // negate remainder at fix-up
    logic             r_bzero;     // divisor was zero for the op in flight
    logic [WIDTH-1:0] r_acc;       // multiply: upper accumulator, divide: remainder
    logic [WIDTH-1:0] r_q;         // multiply: multiplier/low product, divide: quotient
    logic [WIDTH-1:0] r_opnd;      // multiplicand or divisor (magnitude)
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    // ---------------- request decode ----------------
    logic w_is_mul, w_is_div, w_is_muldiv, w_is_mf, w_signed, w_busy, w_accept;

    assign w_is_mul    = (bus.funct == c_F_MULT) || (bus.funct == c_F_MULTU);
    assign w_is_div    = (bus.funct == c_F_DIV)  || (bus.funct == c_F_DIVU);
    assign w_is_muldiv = w_is_mul || w_is_div;
    assign w_is_mf     = (bus.funct == c_F_MFHI) || (bus.funct == c_F_MFLO);
    assign w_signed    = (bus.funct == c_F_MULT) || (bus.funct == c_F_DIV);
    assign w_busy      = (r_state == RUN) || (r_state == FIXUP);

    // DONE also accepts: stall is low there, so a request presented in that
    // cycle will not be re-presented and must be taken now. Flush blocks it.
    assign w_accept = ((r_state == IDLE) || (r_state == DONE)) &&
                      bus.start && w_is_muldiv && !bus.flush;

    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    assign w_abs_a = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_abs_b = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // ---------------- iteration datapath ----------------
    // Multiply step: add multiplicand to the upper half when the multiplier
    // LSB is set, then shift the 2*WIDTH+1 bit {carry, acc, q} right by one.
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_msum;
    assign w_addend = r_q[0] ? r_opnd : '0;
    assign w_msum   = {1'b0, r_acc} + {1'b0, w_addend};

    // Divide step: shifted remainder can need one extra bit before the
    // trial subtract; after a successful subtract it fits WIDTH bits again,
    // so the low WIDTH bits of the difference are sufficient.
    logic [WIDTH:0]   w_rsh;
    logic             w_ge;
    logic [WIDTH-1:0] w_rdiff;
    assign w_rsh   = {r_acc, r_q[WIDTH-1]};
    assign w_ge    = (w_rsh >= {1'b0, r_opnd});
    assign w_rdiff = w_rsh[WIDTH-1:0] - r_opnd;

    // ---------------- fix-up ----------------
    logic [2*WIDTH-1:0] w_prod, w_prod_fx;
    logic [WIDTH-1:0]   w_quo_fx, w_rem_fx;
    assign w_prod    = {r_acc, r_q};
    assign w_prod_fx = r_neg_q ? -w_prod : w_prod;
    assign w_quo_fx  = r_neg_q ? -r_q    : r_q;
    assign w_rem_fx  = r_neg_r ? -r_acc  : r_acc;

    // ---------------- sequencer ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_bzero    <= 1'b0;
            r_acc      <= '0;
            r_q        <= '0;
            r_opnd     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_is_div   <= w_is_div;
                        r_neg_q    <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg_r    <= w_signed && bus.a[WIDTH-1];
                        r_bzero    <= w_is_div && (bus.b == '0);
                        r_div_zero <= 1'b0;
                        r_acc      <= '0;
                        r_cnt      <= '0;
                        r_q        <= w_is_div ? w_abs_a : w_abs_b;
                        r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
                        r_state    <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_acc <= w_ge ? w_rdiff : w_rsh[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], w_ge};
                        end else begin
                            r_acc <= w_msum[WIDTH:1];
                            r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_CW'(WIDTH - 1)) begin
                            r_state <= FIXUP;
                        end
                    end
                end
                FIXUP: begin
                    if (bus.flush) begin
                        r_state <= IDLE;
                    end else begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fx;
                            r_lo <= w_quo_fx;
                        end else begin
                            r_hi <= w_prod_fx[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fx[WIDTH-1:0];
                        end
                        r_div_zero <= r_bzero;
                        r_done     <= 1'b1;
                        r_state    <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign bus.stall    = w_busy && ((bus.start && w_is_muldiv) || w_is_mf);
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
    assign bus.rd_data  = (bus.funct == c_F_MFHI) ? r_hi :
                          (bus.funct == c_F_MFLO) ? r_lo : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_sequencer
// Description : Self-checking bench for muldiv_sequencer. Expected HI/LO and
//               div_zero are computed by a behavioural model when an op is
//               issued and compared by a monitor when done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

    localparam logic [5:0] c_F_MULT  = 6'b011000;
    localparam logic [5:0] c_F_MULTU = 6'b011001;
    localparam logic [5:0] c_F_DIV   = 6'b011010;
    localparam logic [5:0] c_F_DIVU  = 6'b011011;
    localparam logic [5:0] c_F_MFHI  = 6'b010000;
    localparam logic [5:0] c_F_MFLO  = 6'b010010;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_checks;
    int   n_fail;

    muldiv_sequencer_if #(.WIDTH(32)) ifc ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sbv, q, r;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (f)
            c_F_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            c_F_MULT: begin
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            c_F_DIVU: begin
                e.dz = (b == 0);
                e.lo = (b == 0) ? 32'hFFFF_FFFF : a / b;
                e.hi = (b == 0) ? a : a % b;
            end
            default: begin
                e.dz = (b == 0);
                if (b == 0) begin
                    e.lo = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
                    e.hi = a;
                end else begin
                    q = sa / sbv;
                    r = sa % sbv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest issued op.
    always @(negedge clk) begin
        if (!rst && ifc.done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", {63'b0, ifc.done}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("sb_hi", {32'b0, ifc.hi}, {32'b0, e.hi});
                check_eq("sb_lo", {32'b0, ifc.lo}, {32'b0, e.lo});
                check_eq("sb_div_zero", {63'b0, ifc.div_zero}, {63'b0, e.dz});
            end
        end
    end

    // Present an op at a negedge; returns just after the accept edge.
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            input bit track);
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.funct = f;
        ifc.a     = a;
        ifc.b     = b;
        if (track) sb.push_back(model(f, a, b));
        #1;
        check_eq("stall_idle", {63'b0, ifc.stall}, 64'd0);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.funct = 6'd0;
    endtask

    // Count edges from accept to the done pulse; it must be 33 and one cycle wide.
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ifc.done && n < 60);
        check_eq("done_latency", 64'(n), 64'd33);
        @(posedge clk);
        #1;
        check_eq("done_width", {63'b0, ifc.done}, 64'd0);
    endtask

    // Hold a request from cycle 10 of a busy op until the done cycle.
    task automatic busy_request(input logic [5:0] f, input string tag);
        bit seen;
        seen = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        ifc.start = 1'b1;
        ifc.funct = f;
        ifc.a     = 32'd5;
        ifc.b     = 32'd6;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ifc.done) begin
                check_eq({tag, "_stall_done"}, {63'b0, ifc.stall}, 64'd0);
                seen = 1'b1;
                break;
            end
            check_eq({tag, "_stall_busy"}, {63'b0, ifc.stall}, 64'd1);
        end
        check_eq({tag, "_done_seen"}, {63'b0, seen}, 64'd1);
        ifc.start = 1'b0;
        ifc.funct = 6'd0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        ifc.funct = c_F_MFHI;
        #1;
        check_eq({tag, "_hi"},       {32'b0, ifc.hi},       64'd0);
        check_eq({tag, "_lo"},       {32'b0, ifc.lo},       64'd0);
        check_eq({tag, "_done"},     {63'b0, ifc.done},     64'd0);
        check_eq({tag, "_div_zero"}, {63'b0, ifc.div_zero}, 64'd0);
        check_eq({tag, "_stall"},    {63'b0, ifc.stall},    64'd0);
        check_eq({tag, "_rd_data"},  {32'b0, ifc.rd_data},  64'd0);
        ifc.funct = 6'd0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        ifc.start = 1'b0;
        ifc.funct = 6'd0;
        ifc.a     = '0;
        ifc.b     = '0;
        ifc.flush = 1'b0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Multiply
        start_op(c_F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        start_op(c_F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1);
        wait_done();
        @(negedge clk);
        ifc.funct = c_F_MFLO;
        #1;
        check_eq("mflo_data",  {32'b0, ifc.rd_data}, 64'h0000_0000_FFFF_FFEB);
        check_eq("mflo_stall", {63'b0, ifc.stall},   64'd0);
        ifc.funct = c_F_MFHI;
        #1;
        check_eq("mfhi_data",  {32'b0, ifc.rd_data}, 64'h0000_0000_FFFF_FFFF);
        ifc.funct = 6'd0;

        // Divide, including the overflow corner
        start_op(c_F_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done();
        start_op(c_F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        start_op(c_F_DIVU, 32'd1000, 32'd7, 1'b1);
        wait_done();

        // Divide by zero, then the next accept clears the flag
        start_op(c_F_DIVU, 32'd5, 32'd0, 1'b1);
        wait_done();
        check_eq("div_zero_sticky", {63'b0, ifc.div_zero}, 64'd1);
        start_op(c_F_MULTU, 32'd2, 32'd3, 1'b1);
        check_eq("div_zero_clear", {63'b0, ifc.div_zero}, 64'd0);
        wait_done();
        start_op(c_F_DIV, 32'hFFFF_FFF0, 32'd0, 1'b1);
        wait_done();

        // Requests presented while busy
        start_op(c_F_MULTU, 32'h0000_1234, 32'h0000_5678, 1'b1);
        busy_request(c_F_MFHI, "mfhi");
        start_op(c_F_MULTU, 32'hDEAD_BEEF, 32'h0000_0010, 1'b1);
        busy_request(c_F_MULT, "mult");
        repeat (40) @(posedge clk);

        // Preload HI/LO = 0x11111111 / 0x22222222
        start_op(c_F_MULTU, 32'h8000_0001, 32'h2222_2222, 1'b1);
        wait_done();
        check_eq("preload_hi", {32'b0, ifc.hi}, 64'h0000_0000_1111_1111);
        check_eq("preload_lo", {32'b0, ifc.lo}, 64'h0000_0000_2222_2222);

        // Flush mid-divide: back to idle, registers untouched, no done
        start_op(c_F_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        ifc.flush = 1'b1;
        @(posedge clk);
        #1;
        ifc.flush = 1'b0;
        ifc.funct = c_F_MFHI;
        #1;
        check_eq("flush_idle_stall", {63'b0, ifc.stall}, 64'd0);
        ifc.funct = 6'd0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("flush_hi", {32'b0, ifc.hi}, 64'h0000_0000_1111_1111);
        check_eq("flush_lo", {32'b0, ifc.lo}, 64'h0000_0000_2222_2222);

        // Flush and start together in idle: op must not be accepted
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.funct = c_F_MULTU;
        ifc.a     = 32'd3;
        ifc.b     = 32'd3;
        ifc.flush = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        ifc.flush = 1'b0;
        ifc.funct = c_F_MFLO;
        #1;
        check_eq("flush_start_stall", {63'b0, ifc.stall}, 64'd0);
        ifc.funct = 6'd0;
        repeat (40) @(posedge clk);
        #1;
        check_eq("flush_start_lo", {32'b0, ifc.lo}, 64'h0000_0000_2222_2222);

        // Reset mid-divide
        start_op(c_F_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (40) @(posedge clk);
        #1;

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
